// File: rtl/yontem1_ripple_adder.sv
// yontem1_ripple_adder: unsigned ripple-carry adder built from a chain of
// WIDTH one-bit full-adder cells, with a combinational result and a
// registered copy of that result.

// One-bit full adder cell.
module yontem1_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    logic p;

    // Propagate term is shared between the sum and the carry.
    always_comb begin
        p      = a_i ^ b_i;
        s_o    = p ^ cin_i;
        cout_o = (a_i & b_i) | (cin_i & p);
    end

endmodule

module yontem1_ripple_adder #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] num1_i,
    input  logic [WIDTH-1:0] num2_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic [WIDTH-1:0] sum_q_o,
    output logic             cout_q_o
);

    // carry[k] is the carry into cell k; carry[WIDTH] leaves the MSB cell.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    assign carry[0] = 1'b0;

    for (genvar k = 0; k < WIDTH; k++) begin : g_cell
        yontem1_full_adder u_fa (
            .a_i   (num1_i[k]),
            .b_i   (num2_i[k]),
            .cin_i (carry[k]),
            .s_o   (sum_d[k]),
            .cout_o(carry[k+1])
        );
    end

    // Final carry out of the chain.
    always_comb begin
        cout_d = carry[WIDTH];
    end

    // Output register: captures the combinational result on each rising edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum_o    = sum_d;
    assign cout_o   = cout_d;
    assign sum_q_o  = sum_q;
    assign cout_q_o = cout_q;

endmodule

// File: tb/tb_yontem1_ripple_adder.sv
// Directed bench for yontem1_ripple_adder: combinational sums, carry
// boundaries, register latency and asynchronous reset behaviour.
module tb_yontem1_ripple_adder;

    logic        clk_i  = 1'b0;
    logic        rst_i  = 1'b1;
    logic [63:0] num1_i = '0;
    logic [63:0] num2_i = '0;
    logic [63:0] sum_o;
    logic        cout_o;
    logic [63:0] sum_q_o;
    logic        cout_q_o;

    logic clk_en = 1'b0;
    int   passed = 0;
    int   total  = 0;

    yontem1_ripple_adder #(.WIDTH(64)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .num1_i  (num1_i),
        .num2_i  (num2_i),
        .sum_o   (sum_o),
        .cout_o  (cout_o),
        .sum_q_o (sum_q_o),
        .cout_q_o(cout_q_o)
    );

    // Clock only runs once the clocked part of the sequence starts.
    always #5 if (clk_en) clk_i = ~clk_i;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    logic [63:0] a_tab [4] = '{64'd1, 64'd59, 64'd3481, 64'd205379};
    logic [63:0] b_tab [4] = '{64'd1, 64'd73, 64'd5329, 64'd389017};
    logic [63:0] s_tab [16] = '{
        64'd2,      64'd74,     64'd5330,   64'd389018,
        64'd60,     64'd132,    64'd5388,   64'd389076,
        64'd3482,   64'd3554,   64'd8810,   64'd392498,
        64'd205380, 64'd205452, 64'd210708, 64'd594396
    };

    initial begin
        // Power-up with zero operands, reset held, no clock.
        #10;
        check("powerup_comb", {cout_o, sum_o}, {1'b0, 64'd0});
        check("powerup_reg", {cout_q_o, sum_q_o}, {1'b0, 64'd0});

        num1_i = 64'd1; num2_i = 64'd1;
        #10;
        check("one_plus_one", {cout_o, sum_o}, {1'b0, 64'd2});

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                num1_i = a_tab[i];
                num2_i = b_tab[j];
                #10;
                check($sformatf("sweep_%0d_%0d", i, j), {cout_o, sum_o}, {1'b0, s_tab[i*4+j]});
            end
        end

        num1_i = 64'hFFFF_FFFF_FFFF_FFFF; num2_i = 64'd1;
        #10;
        check("full_ripple", {cout_o, sum_o}, {1'b1, 64'd0});

        num1_i = 64'h8000_0000_0000_0000; num2_i = 64'h8000_0000_0000_0000;
        #10;
        check("msb_overflow", {cout_o, sum_o}, {1'b1, 64'd0});

        num1_i = 64'h5555_5555_5555_5555; num2_i = 64'hAAAA_AAAA_AAAA_AAAA;
        #10;
        check("alternating", {cout_o, sum_o}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});

        num1_i = 64'hFFFF_FFFF_FFFF_FFFF; num2_i = 64'hFFFF_FFFF_FFFF_FFFF;
        #10;
        check("max_plus_max", {cout_o, sum_o}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFE});
        check("reg_held_in_reset", {cout_q_o, sum_q_o}, {1'b0, 64'd0});

        // Clocked section.
        num1_i = 64'd3481; num2_i = 64'd5329;
        #2;
        rst_i  = 1'b0;
        clk_en = 1'b1;
        @(posedge clk_i); #1;
        check("reg_first_capture", {cout_q_o, sum_q_o}, {1'b0, 64'd8810});

        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("async_reset_reg", {cout_q_o, sum_q_o}, {1'b0, 64'd0});
        check("async_reset_comb", {cout_o, sum_o}, {1'b0, 64'd8810});
        @(posedge clk_i); #1;
        check("reset_held_over_edge", {cout_q_o, sum_q_o}, {1'b0, 64'd0});

        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        check("recapture", {cout_q_o, sum_q_o}, {1'b0, 64'd8810});

        @(negedge clk_i);
        num1_i = 64'hFFFF_FFFF_FFFF_FFFF; num2_i = 64'd1;
        #1;
        check("latency_before_edge", {cout_q_o, sum_q_o}, {1'b0, 64'd8810});
        @(posedge clk_i); #1;
        check("latency_after_edge", {cout_q_o, sum_q_o}, {1'b1, 64'd0});

        // Operand glitch between edges: only the value at the edge counts.
        @(negedge clk_i);
        num1_i = 64'd59; num2_i = 64'd73;
        #2;
        num1_i = 64'd205379; num2_i = 64'd389017;
        @(posedge clk_i); #1;
        check("edge_value_only", {cout_q_o, sum_q_o}, {1'b0, 64'd594396});

        clk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/yontem1_ripple_adder.md
Name: yontem1_ripple_adder

Overview:
64-bit unsigned ripple-carry adder ("method 1" of the adder comparison set) built from a chain of 64 one-bit full adders. Sum and carry-out are produced combinationally from the operand inputs. An optional output register stage gives a clocked copy of the result for timing-closed integration.

Parameters:
WIDTH, 64, operand/sum width in bits; the chain has exactly WIDTH full-adder cells.

Ports:
clk_i  input  1  clock for the output register stage (rising edge)
rst_i  input  1  asynchronous, active-high reset of the output registers
num1_i  input  WIDTH  operand A, unsigned
num2_i  input  WIDTH  operand B, unsigned
sum_o  output  WIDTH  combinational sum, (num1_i + num2_i) mod 2^WIDTH
cout_o  output  1  combinational carry-out of the MSB cell
sum_q_o  output  WIDTH  registered sum_o
cout_q_o  output  1  registered cout_o

Behaviour:
- Structure: full-adder cell per bit: s = a ^ b ^ cin, cout = (a & b) | (cin & (a ^ b)); bit 0 cin = 0; bit k cin = bit k-1 cout; cout_o = bit WIDTH-1 cout. Generate loop over a separate full-adder submodule; no use of the "+" operator in the datapath.
- sum_o/cout_o are purely combinational: no dependence on clk_i or rst_i; valid within 10 ns of any operand change in zero-delay simulation, including when clk_i is not toggling and rst_i is asserted.
- Arithmetic: unsigned, no carry-in port; overflow wraps modulo 2^WIDTH, with the lost bit reported on cout_o.
- Register stage: on rising clk_i, sum_q_o <= sum_o, cout_q_o <= cout_o; latency 1 cycle from operand sample to registered output.
- Reset: rst_i high asynchronously forces sum_q_o = 0, cout_q_o = 0 immediately, held while rst_i is high; first capture on the first rising clk_i after rst_i deasserts. Reset mid-operation discards the in-flight registered value only; combinational outputs unaffected.
- Power-up with operands at 0: sum_o = 0, cout_o = 0.
- Operands changing between clock edges: only the value present at the rising edge is registered; no glitch filtering required on sum_o.

Test Plan:
- num1_i=1, num2_i=1, no clock -> after 10 ns sum_o=2, cout_o=0.
- Sweep num1_i over powers of 59 below 1,000,000 (1,59,3481,205379) × num2_i over powers of 73 (1,73,5329,389017), 10 ns each -> sum_o equals integer sum every step (e.g. 205379+389017=594396), error count 0.
- num1_i=64'hFFFF_FFFF_FFFF_FFFF, num2_i=1 -> sum_o=0, cout_o=1 (full carry ripple through all 64 cells).
- num1_i=64'h8000_0000_0000_0000, num2_i=64'h8000_0000_0000_0000 -> sum_o=0, cout_o=1; num1_i=64'h5555..., num2_i=64'hAAAA... -> sum_o=all ones, cout_o=0.
- Clocked: rst_i=1 -> sum_q_o=0, cout_q_o=0 without clock edge; release, apply 3481+5329 -> after next rising edge sum_q_o=8810, cout_q_o=0.
- Assert rst_i between edges with sum_q_o=8810 -> sum_q_o drops to 0 immediately while sum_o stays 8810.
